axi_lite_master_bridge: RTL and testbench
=========================================

// Module: axi_lite_master_bridge
// PURPOSE
//  AXI4-lite initiator. Converts a simple single-beat request/response interface
//  (core LSU, ITCM auto-loader) into AXI4-lite transactions toward slaves such as
//  the TCM/flash decoder.
//  One transaction outstanding at a time. Writes drive AW and W concurrently;
//  reads drive AR then wait for R.
// PARAMETERS
//  ADDR_WIDTH  32  request/AXI address width
//  DATA_WIDTH  32  request/AXI data width; STRB width = DATA_WIDTH/8
// PORTS
//  ACLK       in   1     clock
//  ARESETn    in   1     async active-low reset
//  req_valid  in   1     request present
//  req_ready  out  1     bridge idle, accepts request
//  req_wr     in   1     1=write, 0=read
//  req_addr   in   AW    byte address
//  req_wdata  in   DW    write data
//  req_strb   in   DW/8  write byte strobes
//  req_prot   in   3     copied to AWPROT/ARPROT
//  rsp_valid  out  1     one-cycle response pulse
//  rsp_rdata  out  DW    read data, valid with rsp_valid on reads
//  rsp_err    out  1     xRESP!=2'b00, valid with rsp_valid
//  AWVALID/AWREADY/AWADDR/AWPROT     out/in/out/out  1/1/AW/3   write address ch
//  WVALID/WREADY/WDATA/WSTRB         out/in/out/out  1/1/DW/DW/8  write data ch
//  BVALID/BREADY/BRESP               in/out/in       1/1/2      write resp ch
//  ARVALID/ARREADY/ARADDR/ARPROT     out/in/out/out  1/1/AW/3   read address ch
//  RVALID/RREADY/RDATA/RRESP         in/out/in/in    1/1/DW/2   read data ch
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready=0 while ARESETn low); state IDLE.
//   Async assert, sync deassert; req_ready=1 the first cycle after release.
//  States: IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP. All outputs registered.
//  IDLE: req_ready=1. On req_valid&req_ready:
//   - latch addr/prot, plus wdata/strb for writes.
//   - next cycle enter WR_REQ (AWVALID=WVALID=1) or RD_REQ (ARVALID=1).
//  WR_REQ: aw_done/w_done flags set on AWVALID&AWREADY / WVALID&WREADY.
//   - each VALID drops the cycle after its own handshake.
//   - both done (same or different cycles) -> WR_RSP with BREADY=1.
//  WR_RSP: on BVALID&BREADY -> BREADY=0, rsp_valid=1 and rsp_err=|BRESP next cycle.
//   - rsp_rdata holds 0 for writes.
//   - -> IDLE.
//  RD_REQ: on ARVALID&ARREADY -> ARVALID=0, RREADY=1, -> RD_RSP.
//  RD_RSP: on RVALID&RREADY -> RREADY=0, rsp_valid=1, rsp_rdata=RDATA, rsp_err=|RRESP.
//   - -> IDLE.
//  rsp_valid is a single-cycle pulse. The response cycle is also an IDLE cycle
//   (req_ready=1), so back-to-back requests are allowed.
//  Latency, zero-wait slave:
//   - write: accept T0, AW/W T1, BREADY T2, rsp T3.
//   - read: accept T0, AR T1, RREADY T2, rsp T3.
//  VALID is never withdrawn before handshake (AXI rule). AW/AR/W payloads stay
//   stable while VALID is high.
//  req_* inputs are ignored outside IDLE. BVALID/RVALID outside the response
//   states are ignored (READY=0).
//  No timeout: a non-responding slave stalls the bridge until reset.
//  Reset mid-transaction: immediate return to IDLE. No rsp_valid is produced
//   and the pending request is dropped.
// TESTING
//  1. Write 0x1000_0004 data 0xDEADBEEF strb 0xF, zero-wait slave ->
//     AW/W at T1, BREADY T2, rsp_valid T3, rsp_err=0.
//  2. Write with AWREADY at T1, WREADY delayed to T4 ->
//     AWVALID low from T2, WVALID high until T4, BREADY T5, rsp_valid T6.
//  3. Read 0x0000_0100, ARREADY delayed 3 cycles, RDATA 0x12345678 RRESP 0 ->
//     ARVALID stable until handshake, rsp_rdata=0x12345678, rsp_err=0.
//  4. Read answered with RRESP=2'b10 -> rsp_valid with rsp_err=1;
//     write with BRESP=2'b11 -> rsp_err=1.
//  5. Back-to-back write then read, req_valid held -> second request accepted
//     in the rsp_valid cycle of the first; two rsp pulses 3 cycles apart.
//  6. ARESETn low while in WR_REQ with AWVALID high -> all VALID/READY 0
//     immediately, no rsp_valid; req_ready=1 first cycle after release.

Source files
------------

// File: rtl/axi_lite_master_bridge.sv
// axi_lite_master_bridge
//   AXI4-lite initiator. Turns a single-beat request/response handshake into one
//   AXI4-lite transaction at a time. Writes present AW and W together; reads present
//   AR and then wait for R. Every output comes straight from a flop.
// Ports
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_ready high only while idle)
//   req_wr/addr/wdata/strb/prot request payload, sampled on acceptance
//   rsp_valid/rsp_rdata/rsp_err one-cycle response pulse with read data and error flag
//   AW*/W*/B*/AR*/R*           AXI4-lite master channels
module axi_lite_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    WVALID,
    input  logic                    WREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    BVALID,
    output logic                    BREADY,
    input  logic [1:0]              BRESP,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    input  logic                    RVALID,
    output logic                    RREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP
);

    typedef enum logic [2:0] {StIdle, StWrReq, StWrRsp, StRdReq, StRdRsp} state_e;

    state_e state_q, state_d;

    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    req_ready_q, req_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [2:0]              prot_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    // req_ready_q gates acceptance so nothing is taken in the first cycle after reset.
    assign accept = (state_q == StIdle) && req_valid && req_ready_q;
    assign aw_hs  = awvalid_q && AWREADY;
    assign w_hs   = wvalid_q && WREADY;
    assign b_hs   = bready_q && BVALID;
    assign ar_hs  = arvalid_q && ARREADY;
    assign r_hs   = rready_q && RVALID;

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= StIdle;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            prot_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            if (accept) begin
                addr_q <= req_addr;
                prot_q <= req_prot;
                if (req_wr) begin
                    wdata_q <= req_wdata;
                    strb_q  <= req_strb;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = req_wr ? StWrReq : StRdReq;
            end
            StWrReq: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q || w_hs;
                if (aw_done_d && w_done_d) state_d = StWrRsp;
            end
            StWrRsp: if (b_hs) state_d = StIdle;
            StRdReq: if (ar_hs) state_d = StRdRsp;
            StRdRsp: if (r_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state so
    // each VALID drops the cycle after its own handshake.
    always_comb begin
        req_ready_d = (state_d == StIdle);
        awvalid_d   = (state_d == StWrReq) && !aw_done_d;
        wvalid_d    = (state_d == StWrReq) && !w_done_d;
        bready_d    = (state_d == StWrRsp);
        arvalid_d   = (state_d == StRdReq);
        rready_d    = (state_d == StRdRsp);
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if ((state_q == StWrRsp) && b_hs) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = |BRESP;
        end else if ((state_q == StRdRsp) && r_hs) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = |RRESP;
            rsp_rdata_d = RDATA;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign AWVALID   = awvalid_q;
    assign AWADDR    = addr_q;
    assign AWPROT    = prot_q;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = strb_q;
    assign BREADY    = bready_q;
    assign ARVALID   = arvalid_q;
    assign ARADDR    = addr_q;
    assign ARPROT    = prot_q;
    assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge. Inputs and checks happen on the
// falling edge; the DUT samples on the rising edge. Cycle Tn ends at posedge n+1.
module tb_axi_lite_master_bridge;

    logic        ACLK, ARESETn;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int vec_cnt = 0;
    int err_cnt = 0;

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        req_valid = 1'b1; req_wr = wr; req_addr = addr;
        req_wdata = wdata; req_strb = strb; req_prot = prot;
    endtask

    task automatic idle_slave();
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    endtask

    task automatic test_reset();
        ARESETn = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        req_strb = 0; req_prot = 0;
        idle_slave();
        repeat (3) @(negedge ACLK);
        vec_cnt++; if ({req_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b0) begin err_cnt++; $display("FAIL reset_ctl: got %b want 0000000", {req_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
        vec_cnt++; if ({AWADDR, WDATA, rsp_rdata, rsp_err} !== 97'b0) begin err_cnt++; $display("FAIL reset_data: got %h want 0", {AWADDR, WDATA, rsp_rdata, rsp_err}); end
        ARESETn = 1;
        @(negedge ACLK);
        vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_zero_wait();
        drive_req(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010);
        AWREADY = 1; WREADY = 1;
        @(negedge ACLK); // T1
        req_valid = 0;
        vec_cnt++; if ({AWVALID, WVALID, req_ready} !== 3'b110) begin err_cnt++; $display("FAIL wr0_t1_valid: got %b want 110", {AWVALID, WVALID, req_ready}); end
        vec_cnt++; if ({AWADDR, WDATA, WSTRB, AWPROT} !== {32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin err_cnt++; $display("FAIL wr0_t1_payload: got %h %h %h %h want 10000004 deadbeef f 2", AWADDR, WDATA, WSTRB, AWPROT); end
        @(negedge ACLK); // T2
        vec_cnt++; if ({AWVALID, WVALID, BREADY} !== 3'b001) begin err_cnt++; $display("FAIL wr0_t2: got %b want 001", {AWVALID, WVALID, BREADY}); end
        AWREADY = 0; WREADY = 0; BVALID = 1; BRESP = 2'b00;
        @(negedge ACLK); // T3
        vec_cnt++; if ({rsp_valid, rsp_err, BREADY, req_ready} !== 4'b1001) begin err_cnt++; $display("FAIL wr0_t3_rsp: got %b want 1001", {rsp_valid, rsp_err, BREADY, req_ready}); end
        vec_cnt++; if (rsp_rdata !== 32'h0) begin err_cnt++; $display("FAIL wr0_t3_rdata: got %h want 0", rsp_rdata); end
        BVALID = 0;
        @(negedge ACLK); // T4
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL wr0_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_write_wready_late();
        drive_req(1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'h3, 3'b001);
        AWREADY = 1; WREADY = 0;
        @(negedge ACLK); // T1
        req_valid = 0;
        vec_cnt++; if ({AWVALID, WVALID} !== 2'b11) begin err_cnt++; $display("FAIL wr1_t1: got %b want 11", {AWVALID, WVALID}); end
        @(negedge ACLK); // T2
        AWREADY = 0;
        vec_cnt++; if ({AWVALID, WVALID, BREADY} !== 3'b010) begin err_cnt++; $display("FAIL wr1_t2: got %b want 010", {AWVALID, WVALID, BREADY}); end
        @(negedge ACLK); // T3
        vec_cnt++; if ({AWVALID, WVALID, WDATA, WSTRB} !== {2'b01, 32'hCAFE_F00D, 4'h3}) begin err_cnt++; $display("FAIL wr1_t3_hold: got %b %h %h want 01 cafef00d 3", {AWVALID, WVALID}, WDATA, WSTRB); end
        @(negedge ACLK); // T4
        vec_cnt++; if ({WVALID, BREADY} !== 2'b10) begin err_cnt++; $display("FAIL wr1_t4: got %b want 10", {WVALID, BREADY}); end
        WREADY = 1;
        @(negedge ACLK); // T5
        WREADY = 0;
        vec_cnt++; if ({WVALID, BREADY, rsp_valid} !== 3'b010) begin err_cnt++; $display("FAIL wr1_t5: got %b want 010", {WVALID, BREADY, rsp_valid}); end
        BVALID = 1; BRESP = 2'b00;
        @(negedge ACLK); // T6
        BVALID = 0;
        vec_cnt++; if ({rsp_valid, rsp_err} !== 2'b10) begin err_cnt++; $display("FAIL wr1_t6_rsp: got %b want 10", {rsp_valid, rsp_err}); end
        @(negedge ACLK);
    endtask

    task automatic test_read_arready_late();
        drive_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 3'b100);
        @(negedge ACLK); // T1
        req_valid = 0;
        for (int t = 1; t <= 3; t++) begin
            vec_cnt++; if ({ARVALID, ARADDR, ARPROT} !== {1'b1, 32'h0000_0100, 3'b100}) begin err_cnt++; $display("FAIL rd_ar_stable_t%0d: got %b %h %h want 1 00000100 4", t, ARVALID, ARADDR, ARPROT); end
            @(negedge ACLK);
        end
        // T4: ARREADY asserted now
        vec_cnt++; if ({ARVALID, RREADY} !== 2'b10) begin err_cnt++; $display("FAIL rd_t4: got %b want 10", {ARVALID, RREADY}); end
        ARREADY = 1;
        @(negedge ACLK); // T5
        ARREADY = 0;
        vec_cnt++; if ({ARVALID, RREADY} !== 2'b01) begin err_cnt++; $display("FAIL rd_t5: got %b want 01", {ARVALID, RREADY}); end
        RVALID = 1; RDATA = 32'h1234_5678; RRESP = 2'b00;
        @(negedge ACLK); // T6
        RVALID = 0;
        vec_cnt++; if ({rsp_valid, rsp_err, RREADY} !== 3'b100) begin err_cnt++; $display("FAIL rd_t6_rsp: got %b want 100", {rsp_valid, rsp_err, RREADY}); end
        vec_cnt++; if (rsp_rdata !== 32'h1234_5678) begin err_cnt++; $display("FAIL rd_t6_rdata: got %h want 12345678", rsp_rdata); end
        @(negedge ACLK);
    endtask

    task automatic test_error_resp();
        // Read with SLVERR, zero-wait slave
        drive_req(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'b000);
        ARREADY = 1; RVALID = 1; RDATA = 32'hA5A5_0001; RRESP = 2'b10;
        repeat (3) @(negedge ACLK);
        req_valid = 0;
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'hA5A5_0001}) begin err_cnt++; $display("FAIL err_rd: got %b %h want 11 a5a50001", {rsp_valid, rsp_err}, rsp_rdata); end
        idle_slave();
        @(negedge ACLK);
        // Write with DECERR
        drive_req(1'b1, 32'h0000_0300, 32'h5555_AAAA, 4'h1, 3'b000);
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b11;
        repeat (3) @(negedge ACLK);
        req_valid = 0;
        vec_cnt++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b11, 32'h0}) begin err_cnt++; $display("FAIL err_wr: got %b %h want 11 00000000", {rsp_valid, rsp_err}, rsp_rdata); end
        idle_slave();
        @(negedge ACLK);
        vec_cnt++; if ({rsp_valid, req_ready} !== 2'b01) begin err_cnt++; $display("FAIL err_idle: got %b want 01", {rsp_valid, req_ready}); end
    endtask

    task automatic test_back_to_back();
        AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 0;
        ARREADY = 1; RVALID = 1; RDATA = 32'h0BAD_F00D; RRESP = 0;
        drive_req(1'b1, 32'h0000_0400, 32'h1111_2222, 4'hF, 3'b000);
        @(negedge ACLK); // T1: switch to read, still held; must be ignored until idle
        drive_req(1'b0, 32'h0000_0500, 32'h0, 4'h0, 3'b011);
        vec_cnt++; if ({AWVALID, AWADDR} !== {1'b1, 32'h0000_0400}) begin err_cnt++; $display("FAIL b2b_t1: got %b %h want 1 00000400", AWVALID, AWADDR); end
        @(negedge ACLK); // T2
        vec_cnt++; if ({ARVALID, rsp_valid} !== 2'b00) begin err_cnt++; $display("FAIL b2b_t2: got %b want 00", {ARVALID, rsp_valid}); end
        @(negedge ACLK); // T3: first response and acceptance of the read
        vec_cnt++; if ({rsp_valid, req_ready, rsp_rdata} !== {2'b11, 32'h0}) begin err_cnt++; $display("FAIL b2b_rsp1: got %b %h want 11 00000000", {rsp_valid, req_ready}, rsp_rdata); end
        @(negedge ACLK); // T4
        req_valid = 0;
        vec_cnt++; if ({rsp_valid, ARVALID, ARADDR, ARPROT} !== {2'b01, 32'h0000_0500, 3'b011}) begin err_cnt++; $display("FAIL b2b_t4: got %b %h %h want 01 00000500 3", {rsp_valid, ARVALID}, ARADDR, ARPROT); end
        @(negedge ACLK); // T5
        vec_cnt++; if ({rsp_valid, RREADY} !== 2'b01) begin err_cnt++; $display("FAIL b2b_t5: got %b want 01", {rsp_valid, RREADY}); end
        @(negedge ACLK); // T6
        vec_cnt++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0BAD_F00D}) begin err_cnt++; $display("FAIL b2b_rsp2: got %b %h want 1 0badf00d", rsp_valid, rsp_rdata); end
        idle_slave();
        @(negedge ACLK);
    endtask

    task automatic test_reset_mid();
        drive_req(1'b1, 32'h0000_0600, 32'h7777_8888, 4'hF, 3'b000);
        @(negedge ACLK); // T1, AWREADY low so AW/W stay pending
        req_valid = 0;
        vec_cnt++; if ({AWVALID, WVALID} !== 2'b11) begin err_cnt++; $display("FAIL rst_mid_pre: got %b want 11", {AWVALID, WVALID}); end
        #2 ARESETn = 0;
        #1;
        vec_cnt++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid} !== 7'b0) begin err_cnt++; $display("FAIL rst_mid_async: got %b want 0000000", {AWVALID, WVALID, BREADY, ARVALID, RREADY, req_ready, rsp_valid}); end
        AWREADY = 1; WREADY = 1; BVALID = 1;
        @(negedge ACLK);
        vec_cnt++; if ({AWVALID, rsp_valid, req_ready} !== 3'b000) begin err_cnt++; $display("FAIL rst_mid_held: got %b want 000", {AWVALID, rsp_valid, req_ready}); end
        ARESETn = 1;
        @(negedge ACLK);
        vec_cnt++; if ({req_ready, rsp_valid, AWVALID, BREADY} !== 4'b1000) begin err_cnt++; $display("FAIL rst_mid_release: got %b want 1000", {req_ready, rsp_valid, AWVALID, BREADY}); end
        @(negedge ACLK);
        vec_cnt++; if ({rsp_valid, BREADY} !== 2'b00) begin err_cnt++; $display("FAIL rst_mid_no_rsp: got %b want 00", {rsp_valid, BREADY}); end
        idle_slave();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_write_wready_late();
        test_read_arready_late();
        test_error_resp();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
